dmem_lsu: RTL
=============

# dmem_lsu

Parametrised data-memory load/store unit for the pipelined CPU's MEM stage. It replaces the word-only data memory wrapper and adds:
- byte, halfword and word accesses with byte-lane writes;
- sign and zero extension on loads;
- a configurable registered read latency;
- a power-on clear state machine;
- optional misalignment trapping.

The unit holds its own storage array and talks to the pipeline through a valid/ready request port and a valid-only response port.

## Interface
Parameters:
- DEPTH, 4096: storage size in 32-bit words; power of two.
- READ_LAT, 1: load latency in cycles from acceptance to response; legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address, from ALU.C.
- req_wdata  in  32  store data, from RF.rD2; the low byte or low half is used for sb/sh.
- rsp_valid  out  1  load data valid; high for exactly one cycle per load.
- rsp_rdata  out  32  extended load data.
- rsp_err  out  1  high with rsp_valid when the load was misaligned (macro-dependent).

## Operation
- Word index = req_addr[log2(DEPTH)+1:2].
  - Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- Accept condition: req_valid && req_ready. At most one request is accepted per cycle.
- State machine:
  - INIT: entered on rst.
    - A clear counter steps from 0 to DEPTH-1, writing 0 to one word per cycle.
    - req_ready = 0.
    - On the cycle the counter reaches DEPTH-1, that word is cleared and the next state is RUN.
  - RUN: req_ready = 1. Stays in RUN until rst.
- Stores:
  - Word: write all 4 lanes.
  - Half: write lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Byte: write lane addr[1:0] with wdata[7:0].
  - Untouched lanes keep their value. Stores produce no response.
- Loads:
  - Read the word, shift right by 8*addr[1:0], mask to the access size, then sign- or zero-extend per req_unsigned.
  - Extension is applied before entering the latency pipeline.
- Latency pipeline: READ_LAT stages, each holding {valid, data, err}. A response leaves stage READ_LAT.
- Read-after-write: a store accepted in cycle N is visible to a load accepted in cycle N+1 or later.

## Timing
- Reset values: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0; all pipeline valid bits = 0.
- A load accepted in cycle N gives rsp_valid = 1 in cycle N+READ_LAT only. Back-to-back loads give back-to-back responses.
- rsp_rdata and rsp_err hold their last values when rsp_valid = 0.
- A store accepted in cycle N updates the array at the rising edge ending cycle N.
- After rst deasserts, INIT lasts exactly DEPTH cycles; req_ready rises in cycle DEPTH after the first non-reset cycle.
- Reset mid-operation:
  - In-flight loads are dropped and no response is issued.
  - The clear counter restarts at 0.
  - A store presented in the reset cycle is ignored.
- Requests presented while req_ready = 0 are neither performed nor queued. The pipeline must hold them.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A half access with addr[0] != 0, or a word access with addr[1:0] != 0, is misaligned.
  - A misaligned store is suppressed: no array change.
  - A misaligned load returns rsp_rdata = 0 and rsp_err = 1 with normal latency.
- DMEM_MISALIGN_TRAP_EN undefined:
  - Low address bits are forced to natural alignment: half ignores addr[0], word ignores addr[1:0].
  - rsp_err is tied to 0.

## Test plan
- Reset with DEPTH = 16: req_ready stays 0 for 16 cycles, then rises. A lw from 0x3C then returns 0x00000000 after READ_LAT cycles.
- sw 0x8badf00d to 0x10, then lb, lbu, lh and lhu at 0x13 and 0x12:
  - lb 0x13 -> 0xFFFFFF8B; lbu 0x13 -> 0x0000008B.
  - lh 0x12 -> 0xFFFF8BAD; lhu 0x12 -> 0x00008BAD.
- Lane write: sw 0x11223344 to 0x20, sb 0xAA to 0x21, sh 0xBEEF to 0x22, then lw 0x20 -> 0xBEEFAA44.
- READ_LAT = 3, loads accepted in 4 consecutive cycles: rsp_valid high in cycles N+3..N+6, with data in request order. A store accepted in N and a load of the same word in N+1 returns the new data.
- Wrap: with DEPTH = 16, sw to 0x40 followed by lw 0x00 returns the stored value.
- Misalignment: lw 0x22 with the macro defined gives rsp_err = 1 and data 0. A sh to 0x23 leaves memory unchanged. With the macro undefined, lw 0x22 returns the word at 0x20 and rsp_err = 0.
- rst asserted one cycle after a load is accepted: no rsp_valid, and INIT restarts.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: data-memory load/store unit for the MEM stage of the pipelined CPU.
//
// Holds a DEPTH x 32-bit storage array. It supports byte, halfword and word
// stores with byte-lane writes, and sign- or zero-extending loads with a
// registered read latency of READ_LAT cycles. After reset a clear state machine
// zeroes the array one word per cycle before any request is accepted.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses trap. Stores are suppressed, and
//               loads return data 0 with rsp_err = 1.
//   undefined : the low address bits are forced to natural alignment, and
//               rsp_err stays 0.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid/ready  request handshake
//   req_we         1 = store, 0 = load
//   req_size       0 byte, 1 half, 2/3 word
//   req_unsigned   load zero-extend (1) / sign-extend (0)
//   req_addr       byte address (wraps modulo DEPTH*4)
//   req_wdata      store data (low byte/half used for sb/sh)
//   rsp_valid      one-cycle pulse per load
//   rsp_rdata      extended load data (held while rsp_valid = 0)
//   rsp_err        misalignment flag, valid with rsp_valid
module dmem_lsu #(
  parameter int DEPTH    = 4096,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          clr_we;
  logic          run_c;

  logic [31:0]   mem_q [DEPTH];

  logic          acc, st_acc, ld_acc;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          mis;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   rd_word;
  logic [31:0]   ld_data_p0;
  logic          ld_err_p0;

  logic          vld_pn_q  [READ_LAT];
  logic [31:0]   data_pn_q [READ_LAT];
  logic          err_pn_q  [READ_LAT];

  logic          unused_addr_hi;

  // Narrow the shifted word to the access size and extend it to 32 bits.
  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      2'd0:    return uns ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'd1:    return uns ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    run_c     = 1'b0;
    case (state_q)
      S_INIT: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d   = S_RUN;
          clr_cnt_d = '0;
        end
      end
      S_RUN:   run_c = 1'b1;
      default: state_d = S_INIT;
    endcase
  end

  // Ready is masked by rst so that a request in the reset cycle is never taken.
  assign req_ready = run_c && !rst;
  assign acc       = req_valid && req_ready;
  assign st_acc    = acc && req_we;
  assign ld_acc    = acc && !req_we;

  assign idx            = req_addr[AW+1:2];
  assign unused_addr_hi = ^{req_addr[31:AW+2]};

  always_comb begin
    off = req_addr[1:0];
    mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    case (req_size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      default: mis = (off != 2'd0);
    endcase
`else
    case (req_size)
      2'd0:    off = req_addr[1:0];
      2'd1:    off = {req_addr[1], 1'b0};
      default: off = 2'd0;
    endcase
`endif
    case (req_size)
      2'd0: begin
        be = 4'b0001 << off;
        wd = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be = off[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = req_wdata;
      end
    endcase
    rd_word    = mem_q[idx];
    ld_data_p0 = mis ? 32'd0 : extend(rd_word >> {off, 3'b000}, req_size, req_unsigned);
    ld_err_p0  = mis;
  end

  // The clear walk and stores never overlap: stores need RUN, clearing needs INIT.
  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (st_acc && !mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Stage p0 -> pn: extended load data enters the latency pipeline.
  // Data only moves with its valid bit, so the last stage holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < READ_LAT; k++) begin
        vld_pn_q[k]  <= 1'b0;
        data_pn_q[k] <= '0;
        err_pn_q[k]  <= 1'b0;
      end
    end else begin
      vld_pn_q[0] <= ld_acc;
      if (ld_acc) begin
        data_pn_q[0] <= ld_data_p0;
        err_pn_q[0]  <= ld_err_p0;
      end
      for (int k = 1; k < READ_LAT; k++) begin
        vld_pn_q[k] <= vld_pn_q[k-1];
        if (vld_pn_q[k-1]) begin
          data_pn_q[k] <= data_pn_q[k-1];
          err_pn_q[k]  <= err_pn_q[k-1];
        end
      end
    end
  end

  assign rsp_valid = vld_pn_q[READ_LAT-1];
  assign rsp_rdata = data_pn_q[READ_LAT-1];
  assign rsp_err   = err_pn_q[READ_LAT-1];

endmodule
